// File: rtl/serial_mcand_reg.sv
// Serial multiplicand store: bit-serial LSB-first capture from mib, hold, and replay (optionally negated) once per minor cycle.
// First digit appears on the first word_sync strobe after a request; optional parity check under MCAND_PARITY_EN.
module serial_mcand_reg #(
  parameter int WORD_BITS  = 35,
  parameter int SHORT_BITS = 17
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_digit_strobe,
  input  logic i_word_sync,
  input  logic i_load_req,
  input  logic i_long_mode,
  input  logic i_neg_mode,
  input  logic i_emit_req,
  input  logic i_clear_req,
  input  logic i_mib,
`ifdef MCAND_PARITY_EN
  input  logic i_mib_par,
  output logic o_parity_err,
`endif
  output logic o_mcand,
  output logic o_mcand_valid,
  output logic o_loaded,
  output logic o_busy
);
  localparam int CW = $clog2(WORD_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM_LOAD, S_LOAD, S_HOLD, S_ARM_EMIT, S_EMIT
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WORD_BITS-1:0] r_word;
  logic [CW-1:0]        r_cnt;
  logic                 r_long, r_neg, r_seen_one;
  logic                 r_mcand, r_mcand_valid, r_loaded;

  logic          w_sync_strobe, w_cur_bit;
  logic          w_accept_load, w_accept_emit;
  logic          w_cap, w_cap_last, w_shift_out, w_emit_last;
  logic [CW-1:0] w_last_cap;

  assign w_sync_strobe = i_digit_strobe & i_word_sync;
  assign w_cur_bit     = r_word[r_cnt];
  assign w_last_cap    = r_long ? CW'(WORD_BITS - 1) : CW'(SHORT_BITS - 1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept_load = 1'b0;
    w_accept_emit = 1'b0;
    w_cap         = 1'b0;
    w_cap_last    = 1'b0;
    w_shift_out   = 1'b0;
    w_emit_last   = 1'b0;
    if (i_clear_req) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load_req) begin
            w_accept_load = 1'b1;
            w_state_nxt   = S_ARM_LOAD;
          end
        end
        S_HOLD: begin
          if (i_load_req) begin
            w_accept_load = 1'b1;
            w_state_nxt   = S_ARM_LOAD;
          end else if (i_emit_req && r_loaded) begin
            w_accept_emit = 1'b1;
            w_state_nxt   = S_ARM_EMIT;
          end
        end
        S_ARM_LOAD: begin
          if (w_sync_strobe) begin
            w_cap       = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
          // word_sync is deliberately ignored here; only the counter ends the capture
          if (i_digit_strobe) begin
            w_cap = 1'b1;
            if (r_cnt == w_last_cap) begin
              w_cap_last  = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_ARM_EMIT: begin
          if (w_sync_strobe) begin
            w_shift_out = 1'b1;
            w_state_nxt = S_EMIT;
          end
        end
        S_EMIT: begin
          if (i_digit_strobe) begin
            w_shift_out = 1'b1;
            if (r_cnt == CW'(WORD_BITS - 1)) begin
              w_emit_last = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_word        <= '0;
      r_cnt         <= '0;
      r_long        <= 1'b0;
      r_neg         <= 1'b0;
      r_seen_one    <= 1'b0;
      r_mcand       <= 1'b0;
      r_mcand_valid <= 1'b0;
      r_loaded      <= 1'b0;
    end else if (i_clear_req) begin
      r_word        <= '0;
      r_cnt         <= '0;
      r_mcand       <= 1'b0;
      r_mcand_valid <= 1'b0;
      r_loaded      <= 1'b0;
    end else begin
      if (w_accept_load) begin
        r_long   <= i_long_mode;
        r_loaded <= 1'b0;
        r_cnt    <= '0;
      end
      if (w_accept_emit) begin
        r_neg      <= i_neg_mode;
        r_seen_one <= 1'b0;
        r_cnt      <= '0;
      end
      if (w_cap) begin
        r_word[r_cnt] <= i_mib;
        r_cnt         <= r_cnt + 1'b1;
        if (w_cap_last) begin
          r_loaded <= 1'b1;
          r_cnt    <= '0;
          if (!r_long) begin
            for (int i = SHORT_BITS; i < WORD_BITS; i++) r_word[i] <= i_mib;
          end
        end
      end
      // Two's complement on the fly: invert every bit after the first 1 seen
      if (i_digit_strobe) begin
        r_mcand       <= w_shift_out & (w_cur_bit ^ (r_neg & r_seen_one));
        r_mcand_valid <= w_shift_out;
      end
      if (w_shift_out) begin
        r_seen_one <= r_seen_one | w_cur_bit;
        r_cnt      <= w_emit_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

`ifdef MCAND_PARITY_EN
  logic r_par, r_parity_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (i_clear_req || w_accept_load) r_parity_err <= 1'b0;
      if (w_cap) begin
        r_par <= (r_cnt == '0) ? i_mib : (r_par ^ i_mib);
        if (w_cap_last) r_parity_err <= ((r_par ^ i_mib) != i_mib_par);
      end
    end
  end

  assign o_parity_err = r_parity_err;
`endif

  assign o_mcand       = r_mcand;
  assign o_mcand_valid = r_mcand_valid;
  assign o_loaded      = r_loaded;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_HOLD);
endmodule

// File: tb/tb_serial_mcand_reg.sv
// Bench for serial_mcand_reg: vector table, hand-written corner sequences, and random words vs an arithmetic model.
module tb_serial_mcand_reg;
  localparam int WB = 35;
  localparam int SB = 17;

  logic clk = 1'b0;
  logic rst_n, digit_strobe, word_sync, load_req, long_mode, neg_mode;
  logic emit_req, clear_req, mib;
  logic mcand, mcand_valid, loaded, busy;
`ifdef MCAND_PARITY_EN
  logic mib_par, parity_err;
`endif

  serial_mcand_reg #(.WORD_BITS(WB), .SHORT_BITS(SB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digit_strobe(digit_strobe), .i_word_sync(word_sync),
    .i_load_req(load_req), .i_long_mode(long_mode), .i_neg_mode(neg_mode),
    .i_emit_req(emit_req), .i_clear_req(clear_req), .i_mib(mib),
`ifdef MCAND_PARITY_EN
    .i_mib_par(mib_par), .o_parity_err(parity_err),
`endif
    .o_mcand(mcand), .o_mcand_valid(mcand_valid), .o_loaded(loaded), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int dnum   = 0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One digit time: a strobe clock then a quiet clock; samples after each edge.
  task automatic step(input logic b, output logic mc_s, output logic v_s,
                      output logic mc_h, output logic v_h);
    digit_strobe = 1'b1;
    word_sync    = (dnum == 0);
    mib          = b;
    @(posedge clk); #1;
    mc_s = mcand; v_s = mcand_valid;
    digit_strobe = 1'b0;
    word_sync    = 1'b0;
    mib          = 1'($urandom);
    @(posedge clk); #1;
    mc_h = mcand; v_h = mcand_valid;
    dnum = (dnum == WB - 1) ? 0 : dnum + 1;
  endtask

  task automatic pulse(input logic ld, input logic em, input logic cl,
                       input logic lm, input logic ng);
    load_req = ld; emit_req = em; clear_req = cl; long_mode = lm; neg_mode = ng;
    @(posedge clk); #1;
    load_req = 1'b0; emit_req = 1'b0; clear_req = 1'b0;
    long_mode = ~lm; neg_mode = ~ng;
  endtask

  task automatic load_word(input logic [WB-1:0] w, input logic lm);
    logic a, b, c, d;
    pulse(1'b1, 1'b0, 1'b0, lm, 1'b0);
    while (dnum != 0) step(1'($urandom), a, b, c, d);
    for (int k = 0; k < WB; k++) step((lm || k < SB) ? w[k] : 1'($urandom), a, b, c, d);
  endtask

  task automatic emit_check(input logic ng, input logic [WB-1:0] exp, input string nm);
    logic a, b, c, d;
    logic [WB-1:0] g1, g2, v1;
    pulse(1'b0, 1'b1, 1'b0, 1'b0, ng);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    while (dnum != 0) step(1'($urandom), a, b, c, d);
    for (int k = 0; k < WB; k++) begin
      step(1'($urandom), a, b, c, d);
      g1[k] = a; v1[k] = b; g2[k] = c;
    end
    chk(nm, 64'(g1), 64'(exp));
    chk({nm, "_hold"}, 64'(g2), 64'(exp));
    chk({nm, "_valid"}, 64'(v1), {{(64-WB){1'b0}}, {WB{1'b1}}});
    step(1'($urandom), a, b, c, d);
    chk({nm, "_end"}, {62'd0, a, b}, 64'd0);
    chk({nm, "_idle"}, {62'd0, loaded, busy}, 64'd2);
  endtask

  typedef struct {
    logic [WB-1:0] w;
    logic          lm;
    logic          ng;
    logic [WB-1:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[8];
    logic a, b, c, d, vor;
    logic [WB-1:0] w, stored, expv, g;
    logic lm, ng;

    tbl[0] = '{35'h0_0000_0005, 1'b1, 1'b0, 35'h0_0000_0005};
    tbl[1] = '{35'h0_0000_0005, 1'b1, 1'b1, 35'h7_FFFF_FFFB};
    tbl[2] = '{35'h0_0001_0000, 1'b0, 1'b0, 35'h7_FFFF_0000};
    tbl[3] = '{35'h4_0000_0001, 1'b1, 1'b0, 35'h4_0000_0001};
    tbl[4] = '{35'h0_0000_0000, 1'b1, 1'b1, 35'h0_0000_0000};
    tbl[5] = '{35'h4_0000_0000, 1'b1, 1'b1, 35'h4_0000_0000};
    tbl[6] = '{35'h0_0000_FFFF, 1'b0, 1'b1, 35'h7_FFFF_0001};
    tbl[7] = '{35'h0_0001_FFFF, 1'b0, 1'b1, 35'h0_0000_0001};

    rst_n = 1'b0; digit_strobe = 1'b0; word_sync = 1'b0; load_req = 1'b0;
    long_mode = 1'b0; neg_mode = 1'b0; emit_req = 1'b0; clear_req = 1'b0; mib = 1'b0;
`ifdef MCAND_PARITY_EN
    mib_par = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mcand", 64'(mcand), 64'd0);
    chk("rst_valid", 64'(mcand_valid), 64'd0);
    chk("rst_loaded", 64'(loaded), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("emit_unloaded_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      load_word(tbl[i].w, tbl[i].lm);
      chk($sformatf("vec%0d_loaded", i), 64'(loaded), 64'd1);
      emit_check(tbl[i].ng, tbl[i].exp, $sformatf("vec%0d_emit", i));
      emit_check(tbl[i].ng, tbl[i].exp, $sformatf("vec%0d_reemit", i));
    end

    // load wins over emit in HOLD; loaded falls right away
    pulse(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("load_prio_loaded", 64'(loaded), 64'd0);
    chk("load_prio_busy", 64'(busy), 64'd1);
    while (dnum != 0) step(1'($urandom), a, b, c, d);
    for (int k = 0; k < WB; k++) step(k == 3, a, b, c, d);

    // second emit_req during EMIT is neither honoured nor queued
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (dnum != 0) step(1'($urandom), a, b, c, d);
    for (int k = 0; k < 5; k++) begin step(1'($urandom), a, b, c, d); g[k] = a; end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 5; k < WB; k++) begin step(1'($urandom), a, b, c, d); g[k] = a; end
    chk("emit_mid_req_word", 64'(g), 64'h8);
    vor = 1'b0;
    for (int k = 0; k < WB; k++) begin step(1'($urandom), a, b, c, d); vor |= b | d; end
    chk("emit_not_queued", 64'(vor), 64'd0);

    // clear beats load; register empties and later emit is ignored
    pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clear_loaded", 64'(loaded), 64'd0);
    chk("clear_busy", 64'(busy), 64'd0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clear_emit_busy", 64'(busy), 64'd0);
    vor = 1'b0;
    for (int k = 0; k < WB; k++) begin step(1'($urandom), a, b, c, d); vor |= b | d; end
    chk("clear_emit_valid", 64'(vor), 64'd0);

    // reset arriving at digit 10 of a load
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    while (dnum != 0) step(1'($urandom), a, b, c, d);
    for (int k = 0; k < 10; k++) step(1'b1, a, b, c, d);
    rst_n = 1'b0;
    step(1'b1, a, b, c, d);
    rst_n = 1'b1;
    chk("midrst_outs", {60'd0, mcand, mcand_valid, loaded, busy}, 64'd0);
    while (dnum != 0) step(1'b1, a, b, c, d);
    chk("midrst_loaded", 64'(loaded), 64'd0);
    load_word(35'h4_0000_0001, 1'b1);
    emit_check(1'b0, 35'h4_0000_0001, "midrst_emit");

    // random words vs arithmetic model
    for (int i = 0; i < 12; i++) begin
      w  = 35'({$urandom, $urandom});
      lm = 1'($urandom);
      ng = 1'($urandom);
      stored = lm ? w : {{(WB-SB){w[SB-1]}}, w[SB-1:0]};
      expv   = ng ? (35'd0 - stored) : stored;
      load_word(w, lm);
      emit_check(ng, expv, $sformatf("rnd%0d", i));
    end

`ifdef MCAND_PARITY_EN
    mib_par = 1'b0;
    load_word(35'h0_0000_0007, 1'b1);
    chk("parity_bad", 64'(parity_err), 64'd1);
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("parity_clr", 64'(parity_err), 64'd0);
    mib_par = 1'b1;
    while (dnum != 0) step(1'($urandom), a, b, c, d);
    for (int k = 0; k < WB; k++) step(k < 3, a, b, c, d);
    chk("parity_good", 64'(parity_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/serial_mcand_reg.md
Name: serial_mcand_reg

Overview:
- Parametrised serial multiplicand register for the EDSAC arithmetic unit. Successor to the fixed-width multiplicand store.
- Captures a word bit-serially from the memory input bus and holds it by recirculation.
- Replays the word LSB-first to the multiplier once per minor cycle, on request.
- Additions: selectable short/long word with sign extension, and serial two's-complement negation on output.

Parameters:
- WORD_BITS, 35, full (long) word length in bits; also the digit count of one minor cycle.
- SHORT_BITS, 17, short word length; must be < WORD_BITS.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- digit_strobe  input  1  one-cycle pulse per digit time; all shifting occurs only on strobe cycles.
- word_sync  input  1  coincides with the digit_strobe of digit 0 of each minor cycle.
- load_req  input  1  request to capture a word from mib.
- long_mode  input  1  1 = WORD_BITS-wide load; 0 = SHORT_BITS load, sign-extended.
- neg_mode  input  1  1 = emit the negated word.
- emit_req  input  1  request to replay the stored word.
- clear_req  input  1  zero the register.
- mib  input  1  serial memory input bit, LSB first.
- mcand  output  1  serial multiplicand bit, registered.
- mcand_valid  output  1  high on cycles where mcand carries a digit.
- loaded  output  1  register holds a valid word.
- busy  output  1  state is not IDLE or HOLD.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, word = 0, digit counter = 0. Outputs mcand = 0, mcand_valid = 0, loaded = 0, busy = 0. Any in-progress load or emit is aborted; a partial word is discarded.
- States: IDLE, ARM_LOAD, LOAD, HOLD, ARM_EMIT, EMIT.
- IDLE/HOLD + load_req → ARM_LOAD.
  - long_mode is latched at request time.
  - loaded drops to 0 immediately.
- ARM_LOAD: wait for the strobe where word_sync = 1, which is digit 0.
  - That strobe captures mib into bit 0. Go to LOAD with counter = 1.
- LOAD: each strobe captures mib into bit[counter] and increments the counter.
  - Long mode: the final capture is counter = WORD_BITS-1.
  - Short mode: the final capture is counter = SHORT_BITS-1. Bits SHORT_BITS..WORD_BITS-1 are then filled with bit SHORT_BITS-1.
  - On the final capture: go to HOLD, loaded = 1 next cycle.
  - mib on remaining digits of the minor cycle is ignored.
  - word_sync during LOAD is ignored and does not restart the capture.
- HOLD + emit_req → ARM_EMIT; neg_mode is latched at request time.
- ARM_EMIT: on the word_sync strobe, drive bit 0 and go to EMIT with counter = 1.
- EMIT: on each strobe, mcand = output bit for the current digit.
  - mcand and mcand_valid update on the clk edge of the strobe and hold until the next strobe.
  - The word is not destroyed: it recirculates bit-exactly.
  - After digit WORD_BITS-1: go to HOLD; mcand = 0 and mcand_valid = 0 at the next strobe.
  - A new emit_req arriving during EMIT is ignored and is not queued.
- Negation is serial two's complement:
  - Bits up to and including the first 1 pass unchanged; all later bits are inverted.
  - Word 0 stays 0. The most-negative word is emitted unchanged (wraps).
- Priority when requests coincide: clear_req > load_req > emit_req.
  - clear_req in any state: word = 0, loaded = 0, go to IDLE next cycle.
  - load_req is accepted only in IDLE/HOLD; emit_req only in HOLD.
  - Requests made in any other state are dropped.
- emit_req while loaded = 0: ignored.
- busy = 1 in ARM_LOAD, LOAD, ARM_EMIT, EMIT.
- Latency: the first emitted digit appears at the first word_sync strobe after the request is accepted. A full replay takes WORD_BITS strobes.

Optional Feature:
- Macro: MCAND_PARITY_EN.
- Defined:
  - Adds input mib_par (1 bit), sampled on the final load strobe.
  - Adds output parity_err (1 bit, reset 0), which is set when the XOR of the captured bits does not equal mib_par.
  - The captured bits are the SHORT_BITS or WORD_BITS received, before sign extension.
  - parity_err is cleared by the next load_req, clear_req or reset; the loaded word is kept.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Long load of 35'h0_0000_0005, then emit with neg_mode = 0 → mcand digits 1,0,1 then 32 zeros; loaded = 1; a second emit produces the identical sequence.
- Same word, emit with neg_mode = 1 → digits 1,1,0,1 then 31 ones (value 35'h7_FFFF_FFFB).
- Short load of 17'h1_0000 → stored word 35'h7_FFFF_0000; emitted as 16 zeros then 19 ones.
- clear_req and load_req in the same cycle during HOLD → IDLE, loaded = 0, the load is dropped, and the next emit_req is ignored.
- rst_n low at digit 10 of LOAD → all outputs 0, loaded = 0; a subsequent full load of 35'h4_0000_0001 emits 1, 33 zeros, 1.
- With MCAND_PARITY_EN: load 35'h0_0000_0007 with mib_par = 0 → parity_err = 1; with mib_par = 1 → parity_err = 0.
